// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined magnitude comparator: operation encoding
// and the reserved operation codes.
package cmp_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_GE = 3'd0,
    OP_GT = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } op_e;

  localparam logic [OP_W-1:0] OP_RSV6 = 3'd6;
  localparam logic [OP_W-1:0] OP_RSV7 = 3'd7;

endpackage

// File: rtl/cmp_if.sv
// Request/result handshake bundle of the comparator pipeline.
interface cmp_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0]           i0;
  logic [WIDTH-1:0]           i1;
  logic                       signed_cmp;
  logic [cmp_pkg::OP_W-1:0]   op;
  logic                       i_valid;
  logic                       i_ready;
  logic                       o;
  logic                       o_valid;
  logic                       o_ready;

  modport master (
    output i0, i1, signed_cmp, op, i_valid, o_ready,
    input  i_ready, o, o_valid
  );

  modport slave (
    input  i0, i1, signed_cmp, op, i_valid, o_ready,
    output i_ready, o, o_valid
  );

endinterface

// File: rtl/cmp_stage.sv
// One carry-chain segment: adds the low SEG bits of a + ~b + cin, folds segment
// equality into the running flag and registers everything, holding while adv=0.
module cmp_stage
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic             eq_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             valid_q,
  output logic             carry_q,
  output logic             eq_q,
  output logic [OP_W-1:0]  op_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  logic             carry_d;
  logic             eq_d;
  logic [SEG-1:0]   unused_sum;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  always_comb begin
    {carry_d, unused_sum} = {1'b0, a_in[SEG-1:0]} + {1'b0, ~b_in[SEG-1:0]}
                            + {{SEG{1'b0}}, carry_in};
    eq_d = eq_in & (a_in[SEG-1:0] == b_in[SEG-1:0]);
    // Next segment always sits at the bottom of the operand registers
    a_d  = a_in >> SEG;
    b_d  = b_in >> SEG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (adv) begin
      valid_q <= valid_in;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      op_q    <= op_in;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined signed/unsigned comparator: STAGES carry-chain segments followed by a
// registered result decode, all stalling together on back-pressure.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic   clk,
  input logic   rst_n,
  cmp_if.slave  bus
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG         = WIDTH / SAFE_STAGES;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2) begin : g_bad_width
    $error("cmp_pipe: WIDTH must be >= 2");
  end
  if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_stages
    $error("cmp_pipe: STAGES must be >= 1 and divide WIDTH");
  end

  logic [STAGES:0]                  valid_p;
  logic [STAGES:0]                  carry_p;
  logic [STAGES:0]                  eq_p;
  logic [STAGES:0][OP_W-1:0]        op_p;
  logic [STAGES:0][WIDTH-1:0]       a_p;
  logic [STAGES:0][WIDTH-1:0]       b_p;

  logic adv;
  logic o_q, o_d;
  logic o_valid_q;
  logic res;
  logic unused_tail;

  assign adv         = ~o_valid_q | bus.o_ready;
  assign bus.i_ready = adv;

  // Flipping both MSBs maps two's-complement order onto unsigned order
  assign valid_p[0] = bus.i_valid;
  assign carry_p[0] = 1'b1;
  assign eq_p[0]    = 1'b1;
  assign op_p[0]    = bus.op;
  assign a_p[0]     = bus.i0 ^ (bus.signed_cmp ? MSB_MASK : '0);
  assign b_p[0]     = bus.i1 ^ (bus.signed_cmp ? MSB_MASK : '0);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cmp_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .valid_in (valid_p[k]),
      .carry_in (carry_p[k]),
      .eq_in    (eq_p[k]),
      .op_in    (op_p[k]),
      .a_in     (a_p[k]),
      .b_in     (b_p[k]),
      .valid_q  (valid_p[k+1]),
      .carry_q  (carry_p[k+1]),
      .eq_q     (eq_p[k+1]),
      .op_q     (op_p[k+1]),
      .a_q      (a_p[k+1]),
      .b_q      (b_p[k+1])
    );
  end

  // Operand bits are fully consumed once they leave the last segment
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};

  always_comb begin
    res = 1'b0;
    case (op_p[STAGES])
      OP_GE:            res = carry_p[STAGES];
      OP_GT:            res = carry_p[STAGES] & ~eq_p[STAGES];
      OP_LT:            res = ~carry_p[STAGES];
      OP_LE:            res = ~carry_p[STAGES] | eq_p[STAGES];
      OP_EQ:            res = eq_p[STAGES];
      OP_NE:            res = ~eq_p[STAGES];
      OP_RSV6, OP_RSV7: res = 1'b0;
      default:          res = 1'b0;
    endcase
    o_d = valid_p[STAGES] ? res : o_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
    end else if (adv) begin
      o_q       <= o_d;
      o_valid_q <= valid_p[STAGES];
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Randomized and directed bench for cmp_pipe against a slot-level pipeline model
// whose results come from plain integer comparison.
module tb_cmp_pipe;
  import cmp_pkg::*;

  localparam int W   = 16;
  localparam int STG = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // Model: slot STG is the output register; m_o is the held output value
  logic m_v [0:STG];
  logic m_r [0:STG];
  logic m_o;

  cmp_if #(.WIDTH(W)) bus ();

  cmp_pipe #(
    .WIDTH  (W),
    .STAGES (STG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input logic [2:0] op);
    longint la, lb;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'(a);
      lb = longint'(b);
    end
    case (op)
      3'd0:    return la >= lb;
      3'd1:    return la > lb;
      3'd2:    return la < lb;
      3'd3:    return la <= lb;
      3'd4:    return la == lb;
      3'd5:    return la != lb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k <= STG; k++) begin
      m_v[k] = 1'b0;
      m_r[k] = 1'b0;
    end
    m_o = 1'b0;
  endtask

  task automatic model_step();
    logic adv;
    adv = !m_v[STG] || bus.o_ready;
    if (!rst_n) begin
      model_clear();
    end else if (adv) begin
      for (int k = STG; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_r[k] = m_r[k-1];
      end
      m_v[0] = bus.i_valid;
      m_r[0] = ref_cmp(bus.i0, bus.i1, bus.signed_cmp, bus.op);
      if (m_v[STG]) m_o = m_r[STG];
    end
  endtask

  // Check outputs against the model, then advance one clock (ends at negedge)
  task automatic cycle_x(output logic acc, output logic ret, output logic rv,
                         output logic rdy);
    #1;
    check("o_valid", 32'(bus.o_valid), 32'(m_v[STG]));
    check("o", 32'(bus.o), 32'(m_o));
    check("i_ready", 32'(bus.i_ready), 32'(!m_v[STG] || bus.o_ready));
    acc = bus.i_valid && bus.i_ready;
    ret = bus.o_valid && bus.o_ready;
    rv  = bus.o;
    rdy = bus.i_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle();
    logic acc, ret, rv, rdy;
    cycle_x(acc, ret, rv, rdy);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2:0] op, input logic v);
    bus.i0         = a;
    bus.i1         = b;
    bus.signed_cmp = s;
    bus.op         = op;
    bus.i_valid    = v;
  endtask

  task automatic rand_req();
    logic [W-1:0] a, b;
    a = W'($urandom);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ (16'h1 << $urandom_range(0, W - 1));
      default: b = W'($urandom);
    endcase
    drive(a, b, 1'($urandom), 3'($urandom), 1'b1);
  endtask

  // Single request into an idle pipe: checks latency and value
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [2:0] op, input logic exp);
    int lat;
    bus.o_ready = 1'b1;
    drive(a, b, s, op, 1'b1);
    cycle();
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(STG));
    check(tag, 32'(bus.o), 32'(exp));
    cycle();
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   op;
    logic         exp;
  } vec_t;

  vec_t dir_tab[11];

  initial begin
    dir_tab[0]  = '{"eq_ge",   16'h1234, 16'h1234, 1'b0, OP_GE,   1'b1};
    dir_tab[1]  = '{"eq_gt",   16'h1234, 16'h1234, 1'b0, OP_GT,   1'b0};
    dir_tab[2]  = '{"eq_eq",   16'h1234, 16'h1234, 1'b0, OP_EQ,   1'b1};
    dir_tab[3]  = '{"eq_ne",   16'h1234, 16'h1234, 1'b0, OP_NE,   1'b0};
    dir_tab[4]  = '{"u_gt",    16'h8000, 16'h0001, 1'b0, OP_GT,   1'b1};
    dir_tab[5]  = '{"s_gt",    16'h8000, 16'h0001, 1'b1, OP_GT,   1'b0};
    dir_tab[6]  = '{"bnd_lt",  16'h0100, 16'h00ff, 1'b0, OP_LT,   1'b0};
    dir_tab[7]  = '{"bnd_lt2", 16'h00ff, 16'h0100, 1'b0, OP_LT,   1'b1};
    dir_tab[8]  = '{"max_ge",  16'hffff, 16'h0000, 1'b0, OP_GE,   1'b1};
    dir_tab[9]  = '{"rsv6",    16'h1234, 16'h1234, 1'b0, OP_RSV6, 1'b0};
    dir_tab[10] = '{"rsv7",    16'h0000, 16'hffff, 1'b1, OP_RSV7, 1'b0};
  end

  initial begin
    logic [W-1:0] qa [8];
    logic [W-1:0] qb [8];
    logic         qs [8];
    logic [2:0]   qop[8];
    logic         qexp[8];
    logic acc, ret, rv, rdy;
    int sent, got, rc;
    bit stall;

    rst_n = 1'b0;
    bus.o_ready = 1'b1;
    drive('0, '0, 1'b0, 3'd0, 1'b0);
    model_clear();
    #1;
    check("rst_ov", 32'(bus.o_valid), 32'd0);
    check("rst_o", 32'(bus.o), 32'd0);
    check("rst_rdy", 32'(bus.i_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      send(dir_tab[i].tag, dir_tab[i].a, dir_tab[i].b, dir_tab[i].s, dir_tab[i].op,
           dir_tab[i].exp);

    // Eight back-to-back requests, stall cycles 3-6 counted from the first result
    for (int i = 0; i < 8; i++) begin
      qa[i]   = W'($urandom);
      qb[i]   = (i % 3 == 0) ? qa[i] : W'($urandom);
      qs[i]   = 1'($urandom);
      qop[i]  = 3'($urandom_range(0, 5));
      qexp[i] = ref_cmp(qa[i], qb[i], qs[i], qop[i]);
    end
    sent = 0;
    got  = 0;
    rc   = -1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (rc >= 0) rc++;
      else if (bus.o_valid) rc = 0;
      stall = (rc >= 3 && rc <= 6);
      bus.o_ready = !stall;
      if (sent < 8) drive(qa[sent], qb[sent], qs[sent], qop[sent], 1'b1);
      else bus.i_valid = 1'b0;
      cycle_x(acc, ret, rv, rdy);
      if (stall) check("stall_rdy", 32'(rdy), 32'd0);
      if (acc) sent++;
      if (ret && got < 8) begin
        check("order", 32'(rv), 32'(qexp[got]));
        got++;
      end
    end
    check("ret_count", 32'(got), 32'd8);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    repeat (6) cycle();

    // Reset with requests in flight and a result waiting at the output
    bus.o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      cycle();
    end
    bus.i_valid = 1'b0;
    check("pre_rst_ov", 32'(bus.o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(bus.o_valid), 32'd0);
    check("mid_rst_o", 32'(bus.o), 32'd0);
    model_clear();
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    repeat (8) cycle();
    send("post_rst", 16'h7fff, 16'h8000, 1'b1, OP_GT, 1'b1);

    // Random traffic with random back-pressure
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) < 70) rand_req();
      else bus.i_valid = 1'b0;
      bus.o_ready = ($urandom_range(0, 99) < 65);
      cycle();
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
